// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame receiver: line-state enum,
// parity modes, oversample rate and err_out bit positions.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

  localparam int OS_RATE = 16;

  localparam int ERR_PARITY  = 0;
  localparam int ERR_FRAMING = 1;
  localparam int ERR_OVERRUN = 2;
  localparam int ERR_TIMEOUT = 3;

  // Rounded clock cycles per oversample tick.
  function automatic int os_div(input longint clk_hz, input longint baud);
    return int'((clk_hz + baud * (OS_RATE / 2)) / (baud * OS_RATE));
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// Bit-level UART receiver: input synchroniser, 16x oversampling, 3-sample
// majority vote, parity and stop checking. Emits one-cycle byte/error pulses.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int      OS_DIV    = 1,
  parameter parity_e PARITY    = PAR_NONE,
  parameter int      STOP_BITS = 1
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       rx_wire_in,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       parity_err,
  output logic       framing_err,
  output logic       line_idle,
  output logic       start_det,
  output logic       tick
);

  localparam int DIV_W = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;

  rx_state_e        state, state_next;
  logic             rx_meta, rx_sync, rx_prev;
  logic             fall;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       os_cnt;
  logic [3:0]       hi_cnt;
  logic [1:0]       samp;
  logic [7:0]       shift_q;
  logic [2:0]       bit_idx;
  logic             par_bit;
  logic             stop_idx;
  logic             vote, par_bad;
  logic             done_ok, perr, ferr;
  logic             at_s7, at_s8, at_s9, at_end;

  assign tick   = (div_cnt == DIV_W'(OS_DIV - 1));
  assign fall   = rx_prev & ~rx_sync;
  assign at_s7  = tick && (os_cnt == 4'd7);
  assign at_s8  = tick && (os_cnt == 4'd8);
  assign at_s9  = tick && (os_cnt == 4'd9);
  assign at_end = tick && (os_cnt == 4'd15);

  // Ticks 7 and 8 are held in samp; tick 9 is the live synchronised line.
  assign vote = (samp[0] & samp[1]) | (samp[0] & rx_sync) | (samp[1] & rx_sync);

  assign par_bad = (PARITY == PAR_EVEN) ?  (^{shift_q, par_bit}) :
                   (PARITY == PAR_ODD)  ? ~(^{shift_q, par_bit}) : 1'b0;

  assign line_idle = (state == ST_IDLE);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_wire_in;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= ST_IDLE;
    else            state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_next = state;
    start_det  = 1'b0;
    done_ok    = 1'b0;
    perr       = 1'b0;
    ferr       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (fall) begin
          state_next = ST_START;
          start_det  = 1'b1;
        end
      end
      ST_START: begin
        if (at_s8 && rx_sync) state_next = ST_IDLE;
        else if (at_end)      state_next = ST_DATA;
      end
      ST_DATA: begin
        if (at_end && bit_idx == 3'd7)
          state_next = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
      end
      ST_PARITY: begin
        if (at_end) state_next = ST_STOP;
      end
      ST_STOP: begin
        // Leave at mid-stop so the next start edge is never missed.
        if (at_s9) begin
          if (!vote) begin
            state_next = ST_WAIT_HIGH;
            ferr       = 1'b1;
          end else if (stop_idx == 1'(STOP_BITS - 1)) begin
            state_next = ST_IDLE;
            if (par_bad) perr    = 1'b1;
            else         done_ok = 1'b1;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (tick && rx_sync && hi_cnt == 4'd15) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      div_cnt     <= '0;
      os_cnt      <= '0;
      hi_cnt      <= '0;
      samp        <= '0;
      shift_q     <= '0;
      bit_idx     <= '0;
      par_bit     <= 1'b0;
      stop_idx    <= 1'b0;
      byte_data   <= '0;
      byte_valid  <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      if (start_det || tick) div_cnt <= '0;
      else                   div_cnt <= div_cnt + 1'b1;

      if (start_det) os_cnt <= '0;
      else if (tick) os_cnt <= os_cnt + 1'b1;

      if (at_s7) samp[0] <= rx_sync;
      if (at_s8) samp[1] <= rx_sync;

      if (state == ST_DATA && at_s9)   shift_q <= {vote, shift_q[7:1]};
      if (state == ST_PARITY && at_s9) par_bit <= vote;

      if (state == ST_START)                bit_idx <= '0;
      else if (state == ST_DATA && at_end)  bit_idx <= bit_idx + 1'b1;

      if (state != ST_STOP) stop_idx <= 1'b0;
      else if (at_end)      stop_idx <= 1'b1;

      if (state != ST_WAIT_HIGH) hi_cnt <= '0;
      else if (tick)             hi_cnt <= rx_sync ? hi_cnt + 1'b1 : 4'd0;

      if (done_ok) byte_data <= shift_q;
      byte_valid  <= done_ok;
      parity_err  <= perr;
      framing_err <= ferr;
    end
  end

endmodule

// File: rtl/uart_frame_rx.sv
// Assembles FRAME_BYTES received bytes into one frame with a valid/ready
// handshake, overrun detection and an idle timeout on partial frames.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BAUD_RATE    = 115_200,
  parameter int FRAME_BYTES  = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                               clk_in,
  input  logic                               rst_n_in,
  input  logic                               rx_wire_in,
  output logic [8*FRAME_BYTES-1:0]           frame_out,
  output logic                               frame_valid_out,
  input  logic                               frame_ready_in,
  output logic [$clog2(FRAME_BYTES+1)-1:0]   byte_count_out,
  output logic [3:0]                         err_out
);

  localparam int      OS_DIV   = os_div(CLK_HZ, BAUD_RATE);
  localparam int      CNT_W    = $clog2(FRAME_BYTES + 1);
  localparam int      TO_TICKS = TIMEOUT_BITS * OS_RATE;
  localparam int      TO_W     = $clog2(TO_TICKS + 1);
  localparam parity_e PAR_MODE = parity_e'(PARITY);

  if (OS_DIV < 1 || FRAME_BYTES < 1 || FRAME_BYTES > 64 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || TIMEOUT_BITS < 1) begin : g_bad_params
    $error("uart_frame_rx: illegal parameter combination");
  end

  logic [7:0]               rx_byte;
  logic                     byte_valid, perr, ferr;
  logic                     line_idle, start_det, tick;
  logic [8*FRAME_BYTES-1:0] asm_q, full_frame;
  logic [TO_W-1:0]          to_cnt;
  logic                     last_byte, can_load, overrun;
  logic                     to_active, timeout_hit;
  logic [3:0]               err_next;

  uart_byte_rx #(
    .OS_DIV    (OS_DIV),
    .PARITY    (PAR_MODE),
    .STOP_BITS (STOP_BITS)
  ) u_byte_rx (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .rx_wire_in  (rx_wire_in),
    .byte_data   (rx_byte),
    .byte_valid  (byte_valid),
    .parity_err  (perr),
    .framing_err (ferr),
    .line_idle   (line_idle),
    .start_det   (start_det),
    .tick        (tick)
  );

  assign last_byte   = byte_valid && (byte_count_out == CNT_W'(FRAME_BYTES - 1));
  // A same-cycle handshake frees the output register for the new frame.
  assign can_load    = !frame_valid_out || frame_ready_in;
  assign overrun     = last_byte && !can_load;
  assign to_active   = line_idle && (byte_count_out != '0);
  assign timeout_hit = to_active && tick && (to_cnt == TO_W'(TO_TICKS - 1));

  always_comb begin
    full_frame = asm_q;
    full_frame[int'(byte_count_out) * 8 +: 8] = rx_byte;
  end

  always_comb begin
    err_next              = '0;
    err_next[ERR_PARITY]  = perr;
    err_next[ERR_FRAMING] = ferr;
    err_next[ERR_OVERRUN] = overrun;
    err_next[ERR_TIMEOUT] = timeout_hit;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                     to_cnt <= '0;
    else if (start_det || !to_active)  to_cnt <= '0;
    else if (tick)                     to_cnt <= timeout_hit ? '0 : to_cnt + 1'b1;
  end

  // NOTE: the assembly register is plain flops rather than a RAM, so it takes the async reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      asm_q           <= '0;
      byte_count_out  <= '0;
      frame_out       <= '0;
      frame_valid_out <= 1'b0;
      err_out         <= '0;
    end else begin
      if (perr || ferr || timeout_hit) begin
        asm_q          <= '0;
        byte_count_out <= '0;
      end else if (byte_valid) begin
        asm_q[int'(byte_count_out) * 8 +: 8] <= rx_byte;
        byte_count_out <= last_byte ? '0 : byte_count_out + 1'b1;
      end

      if (last_byte && can_load) begin
        frame_out       <= full_frame;
        frame_valid_out <= 1'b1;
      end else if (frame_valid_out && frame_ready_in) begin
        frame_valid_out <= 1'b0;
      end

      err_out <= err_next;
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: frame assembly, overrun, timeout, parity,
// glitch/framing/break handling and mid-frame reset.
module tb_uart_frame_rx;

  localparam int FB  = 4;
  localparam int BIT = 16;
  localparam int CW  = $clog2(FB + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_a = 1'b1, rx_b = 1'b1;
  logic          ready_a = 1'b0, ready_b = 1'b1;
  logic [8*FB-1:0] frame_a, frame_b;
  logic          valid_a, valid_b;
  logic [CW-1:0] cnt_a, cnt_b;
  logic [3:0]    err_a, err_b;

  int n_checks = 0;
  int n_errors = 0;

  int ecnt_a[4];
  int ecnt_b[4];
  int rise_a = 0, rise_b = 0, xfer_a = 0, xfer_b = 0;
  logic valid_a_d = 1'b0, valid_b_d = 1'b0;
  int s_a[4];
  int s_b[4];
  int s_rise_a, s_xfer_a, s_rise_b;

  always #5 clk = ~clk;

  uart_frame_rx #(
    .CLK_HZ(16_000_000), .BAUD_RATE(1_000_000), .FRAME_BYTES(FB),
    .PARITY(0), .STOP_BITS(1), .TIMEOUT_BITS(20)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rx_wire_in(rx_a),
    .frame_out(frame_a), .frame_valid_out(valid_a), .frame_ready_in(ready_a),
    .byte_count_out(cnt_a), .err_out(err_a)
  );

  uart_frame_rx #(
    .CLK_HZ(16_000_000), .BAUD_RATE(1_000_000), .FRAME_BYTES(FB),
    .PARITY(1), .STOP_BITS(1), .TIMEOUT_BITS(20)
  ) dut_par (
    .clk_in(clk), .rst_n_in(rst_n), .rx_wire_in(rx_b),
    .frame_out(frame_b), .frame_valid_out(valid_b), .frame_ready_in(ready_b),
    .byte_count_out(cnt_b), .err_out(err_b)
  );

  // Pulse counters sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (err_a[i]) ecnt_a[i]++;
      if (err_b[i]) ecnt_b[i]++;
    end
    if (valid_a && !valid_a_d) rise_a++;
    if (valid_b && !valid_b_d) rise_b++;
    if (valid_a && ready_a) xfer_a++;
    if (valid_b && ready_b) xfer_b++;
    valid_a_d = valid_a;
    valid_b_d = valid_b;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit on_b, input logic v);
    if (on_b) rx_b = v;
    else      rx_a = v;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit on_b, input bit par_en,
                           input bit par_flip, input bit stop_low);
    drive(on_b, 1'b0);
    cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      drive(on_b, d[i]);
      cyc(BIT);
    end
    if (par_en) begin
      drive(on_b, (^d) ^ par_flip);
      cyc(BIT);
    end
    drive(on_b, !stop_low);
    cyc(BIT);
  endtask

  task automatic snap();
    s_a      = ecnt_a;
    s_b      = ecnt_b;
    s_rise_a = rise_a;
    s_xfer_a = xfer_a;
    s_rise_b = rise_b;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      ecnt_a[i] = 0;
      ecnt_b[i] = 0;
    end

    // Reset state
    cyc(4);
    check("rst_frame", frame_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_count", cnt_a, 0);
    check("rst_err", err_a, 0);
    rst_n = 1'b1;
    cyc(2 * BIT);

    // Basic frame with ready held high
    ready_a = 1'b1;
    snap();
    send_byte(8'h11, 0, 0, 0, 0);
    send_byte(8'h22, 0, 0, 0, 0);
    check("count_after_2", cnt_a, 2);
    send_byte(8'h33, 0, 0, 0, 0);
    send_byte(8'h44, 0, 0, 0, 0);
    cyc(BIT);
    check("frame1_data", frame_a, 32'h44332211);
    check("frame1_rise", rise_a - s_rise_a, 1);
    check("frame1_xfer", xfer_a - s_xfer_a, 1);
    check("frame1_valid_low", valid_a, 0);
    check("frame1_count", cnt_a, 0);
    check("frame1_no_err", (ecnt_a[0] - s_a[0]) + (ecnt_a[1] - s_a[1]) +
                           (ecnt_a[2] - s_a[2]) + (ecnt_a[3] - s_a[3]), 0);

    // Overrun: two frames with ready low
    ready_a = 1'b0;
    snap();
    send_byte(8'hA1, 0, 0, 0, 0);
    send_byte(8'hA2, 0, 0, 0, 0);
    send_byte(8'hA3, 0, 0, 0, 0);
    send_byte(8'hA4, 0, 0, 0, 0);
    cyc(4);
    check("ovr_first_valid", valid_a, 1);
    check("ovr_first_data", frame_a, 32'hA4A3A2A1);
    send_byte(8'hB1, 0, 0, 0, 0);
    send_byte(8'hB2, 0, 0, 0, 0);
    send_byte(8'hB3, 0, 0, 0, 0);
    send_byte(8'hB4, 0, 0, 0, 0);
    cyc(4);
    check("ovr_pulse", ecnt_a[2] - s_a[2], 1);
    check("ovr_held_data", frame_a, 32'hA4A3A2A1);
    check("ovr_held_valid", valid_a, 1);
    check("ovr_count", cnt_a, 0);
    check("ovr_no_xfer_yet", xfer_a - s_xfer_a, 0);
    ready_a = 1'b1;
    cyc(4);
    check("ovr_one_xfer", xfer_a - s_xfer_a, 1);
    check("ovr_valid_fell", valid_a, 0);
    check("ovr_one_rise", rise_a - s_rise_a, 1);

    // Timeout of a partial frame
    snap();
    send_byte(8'h5A, 0, 0, 0, 0);
    send_byte(8'hA5, 0, 0, 0, 0);
    check("to_count_2", cnt_a, 2);
    cyc(19 * BIT);
    check("to_not_yet", ecnt_a[3] - s_a[3], 0);
    check("to_count_still_2", cnt_a, 2);
    cyc(2 * BIT);
    check("to_pulse", ecnt_a[3] - s_a[3], 1);
    check("to_count_cleared", cnt_a, 0);
    send_byte(8'h01, 0, 0, 0, 0);
    send_byte(8'h02, 0, 0, 0, 0);
    send_byte(8'h03, 0, 0, 0, 0);
    send_byte(8'h04, 0, 0, 0, 0);
    cyc(BIT);
    check("to_next_frame", frame_a, 32'h04030201);
    check("to_next_xfer", xfer_a - s_xfer_a, 1);
    check("to_single_pulse", ecnt_a[3] - s_a[3], 1);

    // Parity error on the even-parity instance
    snap();
    send_byte(8'h03, 1, 1, 0, 0);
    check("par_good_count", cnt_b, 1);
    send_byte(8'h07, 1, 1, 1, 0);
    cyc(4);
    check("par_err_pulse", ecnt_b[0] - s_b[0], 1);
    check("par_count_cleared", cnt_b, 0);
    check("par_no_valid", rise_b - s_rise_b, 0);
    check("par_no_framing", ecnt_b[1] - s_b[1], 0);

    // Glitch, framing error, then break
    snap();
    send_byte(8'h99, 0, 0, 0, 0);
    check("glitch_pre_count", cnt_a, 1);
    cyc(BIT);
    rx_a = 1'b0;
    cyc(3);
    rx_a = 1'b1;
    cyc(2 * BIT);
    check("glitch_count", cnt_a, 1);
    check("glitch_no_err", (ecnt_a[0] - s_a[0]) + (ecnt_a[1] - s_a[1]), 0);
    send_byte(8'h55, 0, 0, 0, 1);
    cyc(50 * BIT);
    rx_a = 1'b1;
    cyc(3 * BIT);
    check("frm_pulse", ecnt_a[1] - s_a[1], 1);
    check("frm_count_cleared", cnt_a, 0);
    check("brk_no_other_err", (ecnt_a[0] - s_a[0]) + (ecnt_a[2] - s_a[2]) +
                              (ecnt_a[3] - s_a[3]), 0);
    check("brk_no_valid", rise_a - s_rise_a, 0);

    // Reset asserted while receiving byte 3
    snap();
    send_byte(8'hDE, 0, 0, 0, 0);
    send_byte(8'hAD, 0, 0, 0, 0);
    rx_a = 1'b0;
    cyc(BIT);
    rx_a = 1'b1;
    cyc(3 * BIT + BIT / 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_frame", frame_a, 0);
    check("mid_rst_valid", valid_a, 0);
    check("mid_rst_count", cnt_a, 0);
    check("mid_rst_err", err_a, 0);
    cyc(3);
    rx_a  = 1'b1;
    rst_n = 1'b1;
    cyc(2 * BIT);
    snap();
    send_byte(8'hC0, 0, 0, 0, 0);
    send_byte(8'hFF, 0, 0, 0, 0);
    send_byte(8'hEE, 0, 0, 0, 0);
    send_byte(8'h42, 0, 0, 0, 0);
    cyc(BIT);
    check("post_rst_frame", frame_a, 32'h42EEFFC0);
    check("post_rst_xfer", xfer_a - s_xfer_a, 1);
    check("post_rst_no_err", (ecnt_a[0] - s_a[0]) + (ecnt_a[1] - s_a[1]) +
                             (ecnt_a[2] - s_a[2]) + (ecnt_a[3] - s_a[3]), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
